dtack_gen: RTL and testbench

// - Bus-cycle terminator for the Raven68k 68000 bus. Sits directly downstream of the memory decoder.
// - Consumes the decoder's active-low chip selects and the CPU address strobe.
// - Drives /DTACK to the CPU after a per-region wait count. DUART cycles instead wait for the DUART's own /DTACK.
// - Optionally drives /BERR when a cycle is not terminated in time.

---
 rtl/dtack_gen_pkg.sv | 43 ++++
 rtl/dtack_gen_sync2.sv | 24 ++
 rtl/dtack_gen.sv | 139 +++++++++++++
 tb/tb_dtack_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dtack_gen_pkg.sv
// Shared Raven68k bus definitions: terminator FSM states, decoded regions and
// default wait-state constants used by dtack_gen and the memory decoder docs.
package raven_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT,
    DWAIT,
    HANG,
    ASSERT,
    BERR
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_ROM,
    REG_DUART
  } region_t;

  localparam int DEF_RAM_WAIT = 0;
  localparam int DEF_ROM_WAIT = 2;
  localparam int DEF_WAIT_W   = 4;
`ifdef DTACK_GEN_WATCHDOG_EN
  localparam int DEF_WDOG_CYCLES = 64;
  localparam int DEF_WDOG_W      = 8;
`endif

  // Idle level of the active-low strobes, used as the synchronizer preset.
  localparam logic SYNC_PRESET = 1'b1;

  // Region priority ROM > DUART > RAM; all selects are active-low.
  function automatic region_t decode_region(input logic [1:0] ram_cs,
                                            input logic [1:0] rom_cs,
                                            input logic       duart_cs);
    if (rom_cs != 2'b11) return REG_ROM;
    if (!duart_cs)       return REG_DUART;
    if (ram_cs != 2'b11) return REG_RAM;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/dtack_gen_sync2.sv
// Two-flop synchronizer for active-low asynchronous strobes; both flops
// preset to the inactive (high) level on reset.
module sync2
  import raven_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= SYNC_PRESET;
      q    <= SYNC_PRESET;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dtack_gen.sv
// Raven68k bus-cycle terminator: drives /DTACK after a per-region wait count,
// or after the DUART's own /DTACK. Build with DTACK_GEN_WATCHDOG_EN for /BERR.
module dtack_gen
  import raven_bus_pkg::*;
#(
  parameter int RAM_WAIT = DEF_RAM_WAIT,
  parameter int ROM_WAIT = DEF_ROM_WAIT,
  parameter int WAIT_W   = DEF_WAIT_W
`ifdef DTACK_GEN_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES,
  parameter int WDOG_W      = DEF_WDOG_W
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       as,
  input  logic       ram_evn_cs,
  input  logic       ram_odd_cs,
  input  logic       rom_evn_cs,
  input  logic       rom_odd_cs,
  input  logic       duart_cs,
  input  logic       duart_dtack,
  output logic       dtack,
  output logic       berr,
  output logic       busy,
  output logic [2:0] state_dbg
);

  state_t            state;
  logic [WAIT_W-1:0] wcnt;
  logic              as_s;
  logic              dk_s;
  region_t           region;

  sync2 u_as_sync (.clk(clk), .reset(reset), .d(as),          .q(as_s));
  sync2 u_dk_sync (.clk(clk), .reset(reset), .d(duart_dtack), .q(dk_s));

  // Selects are held stable by the decoder while /AS is low, so no sync needed.
  assign region    = decode_region({ram_evn_cs, ram_odd_cs},
                                   {rom_evn_cs, rom_odd_cs}, duart_cs);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

`ifdef DTACK_GEN_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog;
  logic              wdog_hit;
  assign wdog_hit = (wdog == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign berr = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wcnt  <= '0;
      dtack <= 1'b1;
`ifdef DTACK_GEN_WATCHDOG_EN
      wdog  <= '0;
      berr  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (!as_s) state <= DECODE;
        DECODE: begin
          if (as_s) begin
            state <= IDLE;
          end else begin
            case (region)
              REG_ROM: begin
                wcnt  <= WAIT_W'(ROM_WAIT);
                state <= WAIT;
              end
              REG_RAM: begin
                wcnt  <= WAIT_W'(RAM_WAIT);
                state <= WAIT;
              end
              REG_DUART: state <= DWAIT;
              default:   state <= HANG;
            endcase
          end
        end
        // A strobe release seen on the same edge as wcnt==0 aborts the cycle.
        WAIT: begin
          if (as_s) begin
            state <= IDLE;
            wcnt  <= '0;
          end else if (wcnt == '0) begin
            state <= ASSERT;
            dtack <= 1'b0;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        DWAIT: begin
          if (as_s) begin
            state <= IDLE;
          end else if (!dk_s) begin
            state <= ASSERT;
            dtack <= 1'b0;
          end
        end
        HANG: if (as_s) state <= IDLE;
        ASSERT: begin
          if (as_s) begin
            state <= IDLE;
            dtack <= 1'b1;
          end
        end
        BERR: begin
          if (as_s) begin
            state <= IDLE;
`ifdef DTACK_GEN_WATCHDOG_EN
            berr  <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase

`ifdef DTACK_GEN_WATCHDOG_EN
      if (state == IDLE) begin
        wdog <= '0;
      end else if (state != ASSERT && wdog != '1) begin
        wdog <= wdog + 1'b1;
      end
      // Watchdog expiry overrides any termination scheduled on the same edge.
      if ((state == DECODE || state == WAIT || state == DWAIT || state == HANG)
          && !as_s && wdog_hit) begin
        state <= BERR;
        berr  <= 1'b0;
        dtack <= 1'b1;
        wcnt  <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dtack_gen.sv
// Scoreboard bench for dtack_gen: each bus cycle pushes its expected output
// edges (computed from the cycle-timing rules) and a monitor checks them.
`timescale 1ns/1ps
module tb_dtack_gen;

  localparam int RAM_W = 0;
  localparam int ROM_W = 2;
  localparam int WDOG  = 64;
  localparam int W     = 40;

  localparam logic [7:0] K_BUSY_R = 8'd0;
  localparam logic [7:0] K_DT_F   = 8'd1;
  localparam logic [7:0] K_BE_F   = 8'd2;
  localparam logic [7:0] K_DT_R   = 8'd3;
  localparam logic [7:0] K_BE_R   = 8'd4;
  localparam logic [7:0] K_BUSY_F = 8'd5;

  localparam int R_NONE  = 0;
  localparam int R_RAM   = 1;
  localparam int R_ROM   = 2;
  localparam int R_DUART = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic as = 1'b1;
  logic ram_evn_cs = 1'b1, ram_odd_cs = 1'b1;
  logic rom_evn_cs = 1'b1, rom_odd_cs = 1'b1;
  logic duart_cs = 1'b1, duart_dtack = 1'b1;
  logic dtack, berr, busy;
  logic [2:0] state_dbg;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit mon_en = 1'b0;
  logic p_dtack = 1'b1, p_berr = 1'b1, p_busy = 1'b0;

  dtack_gen dut (
    .clk(clk), .reset(reset), .as(as),
    .ram_evn_cs(ram_evn_cs), .ram_odd_cs(ram_odd_cs),
    .rom_evn_cs(rom_evn_cs), .rom_odd_cs(rom_odd_cs),
    .duart_cs(duart_cs), .duart_dtack(duart_dtack),
    .dtack(dtack), .berr(berr), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic push(input logic [7:0] kind, input int edge_idx);
    exp_q.push_back({kind, 32'(edge_idx)});
  endtask

  task automatic observe(input logic [7:0] kind);
    logic [W-1:0] got, want;
    got = {kind, 32'(cyc)};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind=%0d at edge %0d, none expected", kind, cyc);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL event: got kind=%0d edge=%0d, expected kind=%0d edge=%0d",
                 got[39:32], got[31:0], want[39:32], want[31:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !p_busy)   observe(K_BUSY_R);
      if (!dtack && p_dtack) observe(K_DT_F);
      if (!berr && p_berr)   observe(K_BE_F);
      if (dtack && !p_dtack) observe(K_DT_R);
      if (berr && !p_berr)   observe(K_BE_R);
      if (!busy && p_busy)   observe(K_BUSY_F);
      checks++;
      if (!dtack && !berr) begin
        errors++;
        $display("FAIL both_low: dtack=%b berr=%b at edge %0d, must not both be 0", dtack, berr, cyc);
      end
    end
    p_dtack = dtack;
    p_berr  = berr;
    p_busy  = busy;
  end

  task automatic check(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  // ---------------- driver + reference model ----------------
  // Edge k after /AS falls is E_k; E1 is the first rising edge after the drive.
  // /AS held low through E_h, released before E_(h+1); duart_dtack falls after E_d.
  task automatic run_cycle(input int region, input int h, input int d);
    int t1, rel, f;
    bit fires;
    logic [7:0] fk, rk;
    logic [1:0] r;
    @(negedge clk);
    t1  = cyc + 1;
    rel = h + 3;
    fk = K_DT_F;
    rk = K_DT_R;
    fires = 1'b0;
    case (region)
      R_RAM:   begin f = 5 + RAM_W; fires = (rel > f); end
      R_ROM:   begin f = 5 + ROM_W; fires = (rel > f); end
      R_DUART: begin f = (d + 3 > 5) ? d + 3 : 5; fires = (d < h) && (rel > f); end
      default: begin
`ifdef DTACK_GEN_WATCHDOG_EN
        f = 3 + WDOG; fires = (rel > f); fk = K_BE_F; rk = K_BE_R;
`else
        f = 0; fires = 1'b0;
`endif
      end
    endcase
    push(K_BUSY_R, t1 + 2);
    if (fires) begin
      push(fk, t1 + f - 1);
      push(rk, t1 + rel - 1);
    end
    push(K_BUSY_F, t1 + rel - 1);

    as = 1'b0;
    r = 2'($urandom_range(1, 3));
    case (region)
      R_RAM: begin ram_evn_cs = !r[0]; ram_odd_cs = !r[1]; end
      R_ROM: begin
        rom_evn_cs = !r[0]; rom_odd_cs = !r[1];
        if ($urandom_range(0, 3) == 0) ram_evn_cs = 1'b0;
      end
      R_DUART: begin
        duart_cs = 1'b0;
        if ($urandom_range(0, 3) == 0) ram_odd_cs = 1'b0;
      end
      default: ;
    endcase

    for (int k = 1; k <= h + 6; k++) begin
      @(negedge clk);
      if (region == R_DUART && k == d && k < h) duart_dtack = 1'b0;
      if (k == h) begin
        as = 1'b1;
        duart_dtack = 1'b1;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: region=%0d h=%0d d=%0d, %0d expected edges not seen",
               region, h, d, exp_q.size());
      exp_q.delete();
    end
    {ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs} = 5'b11111;
    duart_dtack = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int region, h, d;
    repeat (3) @(negedge clk);
    check("reset_dtack", dtack, 1'b1);
    check("reset_berr", berr, 1'b1);
    check("reset_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    run_cycle(R_RAM, 6, 0);     // dtack at E5
    run_cycle(R_ROM, 8, 0);     // dtack at E7
    run_cycle(R_DUART, 15, 10); // dtack 3 edges after duart_dtack
    run_cycle(R_RAM, 2, 0);     // release coincides with wcnt==0: no dtack
    run_cycle(R_ROM, 4, 0);     // abort during WAIT
    run_cycle(R_ROM, 5, 0);     // shortest hold that still terminates
    run_cycle(R_DUART, 8, 1);   // early DUART ack: dtack at E5
`ifdef DTACK_GEN_WATCHDOG_EN
    run_cycle(R_NONE, 70, 0);   // berr at E67
    run_cycle(R_NONE, 64, 0);   // release on the expiry edge: no berr
`else
    run_cycle(R_NONE, 20, 0);   // HANG until released
`endif

    for (int i = 0; i < 40; i++) begin
      region = $urandom_range(0, 3);
      d = $urandom_range(1, 12);
`ifdef DTACK_GEN_WATCHDOG_EN
      h = (region == R_NONE) ? $urandom_range(60, 72) : $urandom_range(1, 16);
`else
      h = $urandom_range(1, 16);
`endif
      run_cycle(region, h, d);
    end

    // Asynchronous reset while dtack is asserted.
    mon_en = 1'b0;
    @(negedge clk);
    as = 1'b0;
    ram_evn_cs = 1'b0;
    for (int k = 0; k < 20 && dtack; k++) @(negedge clk);
    check("pre_reset_dtack", dtack, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_dtack", dtack, 1'b1);
    check("async_reset_berr", berr, 1'b1);
    check("async_reset_busy", busy, 1'b0);
    as = 1'b1;
    ram_evn_cs = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    run_cycle(R_RAM, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
